// File: rtl/sseg_capture.sv
// sseg_capture
//   Watches a multiplexed, active-low 7-segment bus and decodes every
//   displayed digit back to its 4-bit value. A digit is captured only after
//   STABLE_CYC identical valid samples. A frame pulse is emitted once every
//   digit position has been captured since the previous frame.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   an           anode selects, active-low (an[i]=0 selects digit i)
//   sseg         segments, active-low, {g,f,e,d,c,b,a}
//   digits       decoded values, digit i at [4i+3:4i]
//   dig_err      1 = last capture of digit i was an illegal pattern
//   frame_valid  one-cycle pulse when all digits were captured
//   frame_err    OR of dig_err, meaningful while frame_valid is high
//   stalled      high while no capture happened for TIMEOUT cycles
module sseg_capture #(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DIG-1:0]     an,
  input  logic [6:0]           sseg,
  output logic [4*N_DIG-1:0]   digits,
  output logic [N_DIG-1:0]     dig_err,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic                 stalled
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_CYC);
  localparam logic [SW-1:0]    STAB_PRE = SW'(STABLE_CYC - 1);
  localparam logic [SW-1:0]    STAB_ONE = SW'(1);
  localparam logic [IW-1:0]    IDLE_MAX = IW'(TIMEOUT);
  localparam logic [IW-1:0]    IDLE_ONE = IW'(1);
  localparam logic [N_DIG-1:0] SEL_ONE  = N_DIG'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;

  // Registered pins and the sample from one cycle earlier.
  logic [N_DIG-1:0]   s_an_q, s_an_d;
  logic [6:0]         s_seg_q, s_seg_d;
  logic [N_DIG-1:0]   p_an_q, p_an_d;
  logic [6:0]         p_seg_q, p_seg_d;

  logic [SW-1:0]      stab_cnt_q, stab_cnt_d;
  logic [1:0]         state_q, state_d;
  logic [4*N_DIG-1:0] digits_q, digits_d;
  logic [N_DIG-1:0]   dig_err_q, dig_err_d;
  logic [N_DIG-1:0]   seen_q, seen_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
  logic               stalled_q, stalled_d;

  logic [N_DIG-1:0]   sel;
  logic [N_DIG-1:0]   sel_m1;
  logic               valid;
  logic               changed;
  logic               capture;
  logic               frame_done;
  logic [3:0]         dec_val;
  logic               dec_err;
  logic [N_DIG-1:0]   cap_en;

  // Active-high segment pattern to {err, value}; illegal patterns give 0.
  function automatic logic [4:0] decode(input logic [6:0] seg_n);
    logic [6:0] seg;
    seg = ~seg_n;
    case (seg)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h7C:   decode = 5'h0B;
      7'h39:   decode = 5'h0C;
      7'h5E:   decode = 5'h0D;
      7'h79:   decode = 5'h0E;
      7'h71:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    s_an_d  = an;
    s_seg_d = sseg;
    p_an_d  = s_an_q;
    p_seg_d = s_seg_q;

    sel     = ~s_an_q;
    sel_m1  = sel - SEL_ONE;
    // Exactly one anode low: nonzero and a power of two.
    valid   = (sel != '0) && ((sel & sel_m1) == '0);
    changed = {s_an_q, s_seg_q} != {p_an_q, p_seg_q};

    {dec_err, dec_val} = decode(s_seg_q);

    if (!valid) begin
      stab_cnt_d = '0;
    end else if (changed) begin
      stab_cnt_d = STAB_ONE;
    end else if (stab_cnt_q == STAB_MAX) begin
      stab_cnt_d = stab_cnt_q;
    end else begin
      stab_cnt_d = stab_cnt_q + STAB_ONE;
    end

    // Capture on the edge where the count climbs to STABLE_CYC.
    capture = (state_q == ST_SETTLE) && valid && !changed &&
              (stab_cnt_q == STAB_PRE);

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (valid) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!valid)       state_d = ST_IDLE;
        else if (capture) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!valid)       state_d = ST_IDLE;
        else if (changed) state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // seen all ones means the previous edge completed the frame; a capture
    // on this edge starts the next frame instead of being dropped.
    frame_done    = &seen_q;
    seen_d        = (frame_done ? '0 : seen_q) | cap_en;
    frame_valid_d = frame_done;
    frame_err_d   = frame_done & (|dig_err_q);

    if (capture) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + IDLE_ONE;
    end
    stalled_d = !capture && (idle_cnt_d == IDLE_MAX);
  end

  // Per-digit capture enables and next values.
  generate
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
      assign cap_en[gi]            = capture & sel[gi];
      assign digits_d[4*gi +: 4]   = cap_en[gi] ? dec_val : digits_q[4*gi +: 4];
      assign dig_err_d[gi]         = cap_en[gi] ? dec_err : dig_err_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      s_an_q        <= '1;
      s_seg_q       <= 7'h7F;
      p_an_q        <= '1;
      p_seg_q       <= 7'h7F;
      stab_cnt_q    <= '0;
      state_q       <= ST_IDLE;
      digits_q      <= '0;
      dig_err_q     <= '0;
      seen_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      idle_cnt_q    <= '0;
      stalled_q     <= 1'b0;
    end else begin
      s_an_q        <= s_an_d;
      s_seg_q       <= s_seg_d;
      p_an_q        <= p_an_d;
      p_seg_q       <= p_seg_d;
      stab_cnt_q    <= stab_cnt_d;
      state_q       <= state_d;
      digits_q      <= digits_d;
      dig_err_q     <= dig_err_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      idle_cnt_q    <= idle_cnt_d;
      stalled_q     <= stalled_d;
    end
  end

  assign digits      = digits_q;
  assign dig_err     = dig_err_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign stalled     = stalled_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture (N_DIG=4, STABLE_CYC=4, TIMEOUT=32).
module tb_sseg_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic [15:0] digits;
  logic [3:0]  dig_err;
  logic        frame_valid;
  logic        frame_err;
  logic        stalled;

  int checks   = 0;
  int failures = 0;

  // Frame monitor: counts pulses and latches the frame contents.
  int          fv_count = 0;
  logic [15:0] fv_digits = '0;
  logic        fv_err = 1'b0;
  logic        saw7 = 1'b0;
  int          base;

  always #5 clk = ~clk;

  sseg_capture #(.N_DIG(4), .STABLE_CYC(4), .TIMEOUT(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .sseg        (sseg),
    .digits      (digits),
    .dig_err     (dig_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .stalled     (stalled)
  );

  always @(posedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_count  = fv_count + 1;
      fv_digits = digits;
      fv_err    = frame_err;
    end
    if (digits[7:4] === 4'h7) saw7 = 1'b1;
  end

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:  seg_of = 7'h3F;  1:  seg_of = 7'h06;  2:  seg_of = 7'h5B;
      3:  seg_of = 7'h4F;  4:  seg_of = 7'h66;  5:  seg_of = 7'h6D;
      6:  seg_of = 7'h7D;  7:  seg_of = 7'h07;  8:  seg_of = 7'h7F;
      9:  seg_of = 7'h6F;  10: seg_of = 7'h77;  11: seg_of = 7'h7C;
      12: seg_of = 7'h39;  13: seg_of = 7'h5E;  14: seg_of = 7'h79;
      default: seg_of = 7'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show_raw(input int idx, input logic [6:0] seg_n, input int n);
    logic [3:0] one;
    one  = 4'b0001;
    an   = ~(one << idx);
    sseg = seg_n;
    step(n);
  endtask

  task automatic show(input int idx, input int v, input int n);
    show_raw(idx, ~seg_of(v), n);
  endtask

  task automatic idle(input int n);
    an   = 4'hF;
    sseg = 7'h7F;
    step(n);
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    sseg  = 7'h7F;
    step(3);
    check("rst_digits",  32'(digits), 32'h0);
    check("rst_dig_err", 32'(dig_err), 32'h0);
    check("rst_fv",      32'(frame_valid), 32'h0);
    check("rst_fe",      32'(frame_err), 32'h0);
    check("rst_stalled", 32'(stalled), 32'h0);
    check("rst_state",   32'(dut.state_q), 32'h0);
    reset = 1'b0;

    // 1: single digit, latency of five cycles from pin change.
    base = fv_count;
    an   = 4'b1110;
    sseg = ~7'h5B;
    step(4);
    check("t1_not_yet",  32'(digits[3:0]), 32'h0);
    step(1);
    check("t1_dig0",     32'(digits[3:0]), 32'h2);
    check("t1_err0",     32'(dig_err[0]), 32'h0);
    step(1);
    idle(2);
    check("t1_no_frame", 32'(fv_count - base), 32'h0);

    // 2: full scan produces exactly one frame.
    base = fv_count;
    show(0, 1, 8);
    show(1, 2, 8);
    show(2, 3, 8);
    show(3, 4, 8);
    idle(3);
    check("t2_frames",   32'(fv_count - base), 32'h1);
    check("t2_fdigits",  32'(fv_digits), 32'h4321);
    check("t2_ferr",     32'(fv_err), 32'h0);

    // 3: a 3-cycle glitch value is never captured.
    show(1, 7, 3);
    show(1, 9, 4);
    idle(3);
    check("t3_dig1",     32'(digits[7:4]), 32'h9);
    check("t3_no_glitch", 32'(saw7), 32'h0);

    // 4: invalid anodes, stall timeout and its release.
    show(0, 5, 5);
    check("t4_dig0",     32'(digits[3:0]), 32'h5);
    check("t4_stall0",   32'(stalled), 32'h0);
    an   = 4'b1100;
    sseg = ~seg_of(8);
    step(10);
    check("t4_nocap",    32'(digits), 32'h4395);
    check("t4_idle_st",  32'(dut.state_q), 32'h0);
    idle(21);
    check("t4_stall31",  32'(stalled), 32'h0);
    step(1);
    check("t4_stall32",  32'(stalled), 32'h1);
    show(3, 6, 4);
    check("t4_stall_hold", 32'(stalled), 32'h1);
    step(1);
    check("t4_stall_clr", 32'(stalled), 32'h0);
    check("t4_dig3",     32'(digits[15:12]), 32'h6);

    // 5: illegal pattern on digit 2 after a fresh reset.
    idle(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("t5_rst_digits", 32'(digits), 32'h0);
    base = fv_count;
    show(0, 10, 8);
    show(1, 11, 8);
    show_raw(2, ~7'h01, 8);
    show(3, 12, 8);
    idle(3);
    check("t5_frames",   32'(fv_count - base), 32'h1);
    check("t5_fdigits",  32'(fv_digits), 32'hC0BA);
    check("t5_ferr",     32'(fv_err), 32'h1);
    check("t5_dig_err",  32'(dig_err), 32'h4);
    check("t5_dig2",     32'(digits[11:8]), 32'h0);

    // 6: reset discards a partial frame.
    base = fv_count;
    show(0, 9, 8);
    show(1, 8, 8);
    show(2, 7, 8);
    reset = 1'b1;
    an    = 4'hF;
    sseg  = 7'h7F;
    step(2);
    reset = 1'b0;
    check("t6_rst_digits",  32'(digits), 32'h0);
    check("t6_rst_dig_err", 32'(dig_err), 32'h0);
    check("t6_rst_fv",      32'(frame_valid), 32'h0);
    check("t6_rst_stalled", 32'(stalled), 32'h0);
    check("t6_no_frame",    32'(fv_count - base), 32'h0);
    idle(2);
    show(3, 1, 8);
    show(2, 2, 8);
    show(1, 3, 8);
    show(0, 4, 8);
    idle(3);
    check("t6_frames",   32'(fv_count - base), 32'h1);
    check("t6_fdigits",  32'(fv_digits), 32'h1234);
    check("t6_ferr",     32'(fv_err), 32'h0);
    check("t6_digits",   32'(digits), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
